multi_bin_selector: RTL and testbench



---
 rtl/multi_bin_selector.sv | 233 +++++++++++++++++++++++
 tb/tb_multi_bin_selector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_bin_selector.sv
// Multi-slot FFT bin selector with a double-buffered bin table and an AXI4-Stream output FIFO.
// Optional build macro FREQ_SEL_BYPASS_EN: when defined, bypass=1 forwards every bin.
module multi_bin_selector #(
    parameter int DATA_W     = 64,
    parameter int K_W        = 14,
    parameter int N_SEL      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 16384,
    localparam int SLOT_W    = $clog2(N_SEL)
) (
    input  logic                  dev_clk,
    input  logic                  dev_rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [K_W-1:0]        k_in,
    input  logic                  valid_in,
    input  logic                  cfg_we,
    input  logic [SLOT_W-1:0]     cfg_addr,
    input  logic [K_W-1:0]        cfg_k,
    input  logic                  cfg_en,
    input  logic                  cfg_clr,
    input  logic                  bypass,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [SLOT_W+K_W-1:0] m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  en,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = SLOT_W + K_W;
    localparam logic [K_W-1:0] LAST_BIN = K_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [UW-1:0]     user;
        logic              last;
    } word_t;

    // ------------------------------------------------------------------
    // Bin tables: cfg writes land in shadow, copied to active at frame end
    // ------------------------------------------------------------------
    logic [K_W-1:0]   shadow_k [N_SEL];
    logic [N_SEL-1:0] shadow_en;
    logic [K_W-1:0]   active_k [N_SEL];
    logic [N_SEL-1:0] active_en;
    logic [K_W-1:0]   last_k;
    logic [K_W-1:0]   shadow_max;
    logic             commit_pending;

    // NOTE: always_comb uses blocking '=' so each loop iteration sees the running
    // maximum; clocked blocks use '<=' so every register samples pre-edge values.
    always_comb begin
        shadow_max = '0;
        for (int i = 0; i < N_SEL; i++) begin
            if (shadow_en[i] && (shadow_k[i] > shadow_max))
                shadow_max = shadow_k[i];
        end
    end

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            shadow_en      <= '0;
            active_en      <= '0;
            last_k         <= '0;
            en             <= 1'b0;
            commit_pending <= 1'b0;
            for (int i = 0; i < N_SEL; i++) begin
                shadow_k[i] <= '0;
                active_k[i] <= '0;
            end
        end else begin
            commit_pending <= valid_in && (k_in == LAST_BIN);
            if (cfg_we) begin
                shadow_k[cfg_addr]  <= cfg_k;
                shadow_en[cfg_addr] <= cfg_en;
            end
            // A write on this same cycle is not yet visible here; it waits a frame.
            if (commit_pending) begin
                active_k  <= shadow_k;
                active_en <= shadow_en;
                last_k    <= shadow_max;
                en        <= |shadow_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: input register
    // ------------------------------------------------------------------
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [K_W-1:0]    s1_k;

    always_ff @(posedge dev_clk) begin
        if (dev_rst) s1_valid <= 1'b0;
        else         s1_valid <= valid_in;
    end

    always_ff @(posedge dev_clk) begin
        s1_data <= data_in;
        s1_k    <= k_in;
    end

`ifdef FREQ_SEL_BYPASS_EN
    logic s1_bypass;
    always_ff @(posedge dev_clk) begin
        if (dev_rst) s1_bypass <= 1'b0;
        else         s1_bypass <= bypass;
    end
`else
    logic unused_bypass;
    assign unused_bypass = bypass;
`endif

    // ------------------------------------------------------------------
    // S2: parallel compare against the active table
    // ------------------------------------------------------------------
    logic              hit;
    logic [SLOT_W-1:0] hit_slot;
    logic              s2_push_d;
    logic [SLOT_W-1:0] s2_slot_d;
    logic              s2_last_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        // Descending scan: the lowest-numbered matching slot is written last and wins.
        for (int i = N_SEL - 1; i >= 0; i--) begin
            if (active_en[i] && (active_k[i] == s1_k)) begin
                hit      = 1'b1;
                hit_slot = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        s2_push_d = s1_valid && hit;
        s2_slot_d = hit_slot;
        s2_last_d = (s1_k == last_k);
`ifdef FREQ_SEL_BYPASS_EN
        if (s1_bypass) begin
            s2_push_d = s1_valid;
            s2_slot_d = '0;
            s2_last_d = (s1_k == LAST_BIN);
        end
`endif
    end

    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic [SLOT_W-1:0] s2_slot;
    logic [K_W-1:0]    s2_k;
    logic              s2_last;

    always_ff @(posedge dev_clk) begin
        if (dev_rst) s2_valid <= 1'b0;
        else         s2_valid <= s2_push_d;
    end

    always_ff @(posedge dev_clk) begin
        s2_data <= s1_data;
        s2_slot <= s2_slot_d;
        s2_k    <= s1_k;
        s2_last <= s2_last_d;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    word_t         mem [FIFO_DEPTH];
    word_t         head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && m_axis_tready;
    assign push_ok = s2_valid && (!full || pop);
    assign drop    = s2_valid && full && !pop;

    // NOTE: the storage array is not reset; the pointers define which entries are
    // meaningful, and the output is forced to zero while the FIFO is empty.
    always_ff @(posedge dev_clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= '{data: s2_data, user: {s2_slot, s2_k}, last: s2_last};
    end

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : head.data;
    assign m_axis_tuser  = empty ? '0 : head.user;
    assign m_axis_tlast  = !empty && head.last;

    // ------------------------------------------------------------------
    // Drop accounting: a drop outranks a simultaneous clear
    // ------------------------------------------------------------------
    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (cfg_clr)
                drop_cnt <= 16'd1;
            else if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end else if (cfg_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_multi_bin_selector.sv
// Directed self-checking bench for multi_bin_selector (short frames, 32 slots, 16-entry FIFO).
module tb_multi_bin_selector;

    localparam int DATA_W     = 64;
    localparam int K_W        = 14;
    localparam int N_SEL      = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int FRAME_LEN  = 64;
    localparam int SLOT_W     = $clog2(N_SEL);
    localparam int UW         = SLOT_W + K_W;

    logic              dev_clk;
    logic              dev_rst;
    logic [DATA_W-1:0] data_in;
    logic [K_W-1:0]    k_in;
    logic              valid_in;
    logic              cfg_we;
    logic [SLOT_W-1:0] cfg_addr;
    logic [K_W-1:0]    cfg_k;
    logic              cfg_en;
    logic              cfg_clr;
    logic              bypass;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              en;
    logic              overflow;
    logic [15:0]       drop_cnt;

    multi_bin_selector #(
        .DATA_W(DATA_W), .K_W(K_W), .N_SEL(N_SEL),
        .FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .dev_clk(dev_clk), .dev_rst(dev_rst),
        .data_in(data_in), .k_in(k_in), .valid_in(valid_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_k(cfg_k), .cfg_en(cfg_en),
        .cfg_clr(cfg_clr), .bypass(bypass),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .en(en), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial dev_clk = 1'b0;
    always #5 dev_clk = ~dev_clk;

    int cyc = 0;
    always @(posedge dev_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [UW-1:0]     user;
        logic              last;
        int                cyc;
    } obs_t;

    obs_t got[$];
    int   in_cyc [FRAME_LEN];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Every accepted beat is logged mid-cycle, away from the active edge.
    always @(negedge dev_clk) begin
        obs_t o;
        if (m_axis_tvalid && m_axis_tready) begin
            o.data = m_axis_tdata;
            o.user = m_axis_tuser;
            o.last = m_axis_tlast;
            o.cyc  = cyc;
            got.push_back(o);
        end
    end

    function automatic logic [63:0] dat(input int fr, input int k);
        return {16'hDA7A, fr[15:0], 16'h0000, k[15:0]};
    endfunction

    function automatic logic [UW-1:0] usr(input int slot, input int k);
        return {SLOT_W'(slot), K_W'(k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge dev_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input int slot, input int k, input bit e);
        cfg_we   = 1'b1;
        cfg_addr = SLOT_W'(slot);
        cfg_k    = K_W'(k);
        cfg_en   = e;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Streams bins 0..n_bins-1; optional hooks fire on the cycle bin 'x_at' is driven.
    task automatic send_frame(input int fr, input int n_bins,
                              input int wr_at, input int wr_slot, input int wr_k,
                              input int rdy_at, input int clr_at);
        for (int k = 0; k < n_bins; k++) begin
            data_in  = dat(fr, k);
            k_in     = K_W'(k);
            valid_in = 1'b1;
            cfg_we   = (k == wr_at);
            if (k == wr_at) begin
                cfg_addr = SLOT_W'(wr_slot);
                cfg_k    = K_W'(wr_k);
                cfg_en   = 1'b1;
            end
            cfg_clr = (k == clr_at);
            if (k == rdy_at) m_axis_tready = 1'b1;
            in_cyc[k] = cyc;
            tick();
        end
        valid_in = 1'b0;
        cfg_we   = 1'b0;
        cfg_clr  = 1'b0;
    endtask

    task automatic plain_frame(input int fr);
        send_frame(fr, FRAME_LEN, -1, 0, 0, -1, -1);
    endtask

    task automatic expect_word(input string tag, input int idx, input int fr,
                               input int slot, input int k, input bit last);
        check({tag, ".present"}, 64'(got.size() > idx), 64'd1);
        if (got.size() > idx) begin
            check({tag, ".tdata"}, got[idx].data, dat(fr, k));
            check({tag, ".tuser"}, 64'(got[idx].user), 64'(usr(slot, k)));
            check({tag, ".tlast"}, 64'(got[idx].last), 64'(last));
        end
    endtask

    initial begin
        dev_rst = 1'b1; data_in = '0; k_in = '0; valid_in = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_k = '0; cfg_en = 1'b0; cfg_clr = 1'b0;
        bypass = 1'b0; m_axis_tready = 1'b1;
        ticks(3);
        check("rst.tvalid",   64'(m_axis_tvalid), 64'd0);
        check("rst.tlast",    64'(m_axis_tlast),  64'd0);
        check("rst.tdata",    m_axis_tdata,       64'd0);
        check("rst.tuser",    64'(m_axis_tuser),  64'd0);
        check("rst.en",       64'(en),            64'd0);
        check("rst.overflow", 64'(overflow),      64'd0);
        check("rst.drop_cnt", 64'(drop_cnt),      64'd0);
        dev_rst = 1'b0;
        tick();

        // Program three slots (two duplicates); first frame runs on the empty active table.
        cfg_write(0, 5, 1'b1);
        cfg_write(1, 9, 1'b1);
        cfg_write(2, 9, 1'b1);
        plain_frame(1);
        check("t1.en_before_commit", 64'(en), 64'd0);
        tick();
        check("t1.en_after_commit", 64'(en), 64'd1);
        ticks(4);
        check("t1.frame1_words", 64'(got.size()), 64'd0);
        plain_frame(2);
        ticks(5);
        check("t1.frame2_words", 64'(got.size()), 64'd2);
        expect_word("t1.w0", 0, 2, 0, 5, 1'b0);
        expect_word("t1.w1", 1, 2, 1, 9, 1'b1);
        if (got.size() == 2) begin
            check("t1.lat_k5", 64'(got[0].cyc - in_cyc[5]), 64'd3);
            check("t1.lat_k9", 64'(got[1].cyc - in_cyc[9]), 64'd3);
        end
        got.delete();

        // Mid-frame shadow rewrite of slot 0 only shows up one frame later.
        cfg_write(1, 9, 1'b0);
        cfg_write(2, 9, 1'b0);
        send_frame(3, FRAME_LEN, 20, 0, 7, -1, -1);
        ticks(5);
        check("t2.frame3_words", 64'(got.size()), 64'd2);
        expect_word("t2.f3w0", 0, 3, 0, 5, 1'b0);
        expect_word("t2.f3w1", 1, 3, 1, 9, 1'b1);
        got.delete();
        plain_frame(4);
        ticks(5);
        check("t2.frame4_words", 64'(got.size()), 64'd1);
        expect_word("t2.f4w0", 0, 4, 0, 7, 1'b1);
        got.delete();

        // Twenty consecutive bins into a stalled 16-entry FIFO.
        for (int s = 0; s < 20; s++) cfg_write(s, 10 + s, 1'b1);
        plain_frame(5);
        ticks(5);
        check("t3.frame5_words", 64'(got.size()), 64'd1);
        expect_word("t3.f5w0", 0, 5, 0, 7, 1'b1);
        got.delete();
        m_axis_tready = 1'b0;
        plain_frame(6);
        ticks(3);
        check("t3.tvalid",   64'(m_axis_tvalid), 64'd1);
        check("t3.tdata",    m_axis_tdata,       dat(6, 10));
        check("t3.tuser",    64'(m_axis_tuser),  64'(usr(0, 10)));
        check("t3.overflow", 64'(overflow),      64'd1);
        check("t3.drop_cnt", 64'(drop_cnt),      64'd4);
        ticks(5);
        check("t3.tdata_hold", m_axis_tdata,       dat(6, 10));
        check("t3.tuser_hold", 64'(m_axis_tuser),  64'(usr(0, 10)));
        check("t3.tlast_hold", 64'(m_axis_tlast),  64'd0);
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        check("t3.clr_overflow", 64'(overflow), 64'd0);
        check("t3.clr_drop_cnt", 64'(drop_cnt), 64'd0);
        m_axis_tready = 1'b1;
        ticks(20);
        check("t3.drain_words", 64'(got.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            expect_word($sformatf("t3.d%0d", i), i, 6, i, 10 + i, 1'b0);
        got.delete();

        // Ready rises exactly when the FIFO is full and the next push arrives.
        m_axis_tready = 1'b0;
        send_frame(7, FRAME_LEN, -1, 0, 0, 28, -1);
        ticks(6);
        check("t4.overflow", 64'(overflow), 64'd0);
        check("t4.drop_cnt", 64'(drop_cnt), 64'd0);
        check("t4.words",    64'(got.size()), 64'd20);
        for (int i = 0; i < 20; i++)
            expect_word($sformatf("t4.d%0d", i), i, 7, i, 10 + i, i == 19);
        got.delete();

        // Clear coinciding with the second drop: drop wins, count restarts at 1.
        m_axis_tready = 1'b0;
        send_frame(8, FRAME_LEN, -1, 0, 0, -1, 29);
        check("t5.overflow", 64'(overflow), 64'd1);
        check("t5.drop_cnt", 64'(drop_cnt), 64'd3);
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        m_axis_tready = 1'b1;
        ticks(20);
        check("t5.words", 64'(got.size()), 64'd16);
        expect_word("t5.last_kept", 15, 8, 15, 25, 1'b0);
        got.delete();

        // Mid-frame reset with three words queued.
        m_axis_tready = 1'b0;
        send_frame(9, 13, -1, 0, 0, -1, -1);
        ticks(3);
        check("t6.queued_tvalid", 64'(m_axis_tvalid), 64'd1);
        dev_rst = 1'b1;
        tick();
        dev_rst = 1'b0;
        check("t6.tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6.en",     64'(en),            64'd0);
        m_axis_tready = 1'b1;
        plain_frame(10);
        plain_frame(11);
        ticks(5);
        check("t6.no_words", 64'(got.size()), 64'd0);
        check("t6.en_idle",  64'(en),         64'd0);
        cfg_write(3, 40, 1'b1);
        plain_frame(12);
        tick();
        check("t6.en_reprog", 64'(en), 64'd1);
        ticks(4);
        check("t6.frame12_words", 64'(got.size()), 64'd0);
        plain_frame(13);
        ticks(5);
        check("t6.frame13_words", 64'(got.size()), 64'd1);
        expect_word("t6.w0", 0, 13, 3, 40, 1'b1);
        got.delete();

        // Bypass request.
        bypass = 1'b1;
        tick();
        plain_frame(14);
        ticks(5);
`ifdef FREQ_SEL_BYPASS_EN
        begin
            int n_last = 0;
            foreach (got[i]) if (got[i].last) n_last++;
            check("t7.words",  64'(got.size()), 64'(FRAME_LEN));
            check("t7.n_last", 64'(n_last),     64'd1);
            expect_word("t7.w10",   10,            14, 0, 10,            1'b0);
            expect_word("t7.wlast", FRAME_LEN - 1, 14, 0, FRAME_LEN - 1, 1'b1);
        end
`else
        check("t7.words", 64'(got.size()), 64'd1);
        expect_word("t7.w0", 0, 14, 3, 40, 1'b1);
`endif
        got.delete();
        bypass = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
